// File: rtl/etapa_id_segmentada.sv
// -----------------------------------------------------------------------------
// etapa_id_segmentada
//
// Instruction-decode stage of the pipelined MIPS core. It sits between the
// IF/ID register and the EX stage. Each cycle it:
//   - decodes the IF/ID instruction into control bits,
//   - reads rs/rt from the register bank, with an optional same-cycle
//     write-through from WB,
//   - detects load-use hazards against the load currently in EX,
//   - resolves J in ID (target and taken flag are combinational),
//   - registers every decoded field into the ID/EX pipeline register.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   instruccion_if[31:0]     instruction held in IF/ID
//   pc_plus4_if[31:0]        PC+4 held in IF/ID
//   valido_if                IF/ID holds a real instruction
//   wb_escribir/wb_rd/wb_dato  register write port driven by WB
//   ex_mem_leer_in/ex_rt_in  the instruction in EX is a load into ex_rt_in
//   flush                    a taken branch downstream kills the ID slot
//   stall_if                 hold PC and IF/ID (combinational)
//   salto_id/dir_salto       J taken this cycle and its target (combinational)
//   ex_*                     ID/EX pipeline register contents
//
// Pipeline handshake: valido_if qualifies the IF/ID slot. When stall_if is
// high the upstream stages must hold PC and IF/ID unchanged, and this stage
// inserts a bubble (all ex_* = 0) into ID/EX. flush has priority over a stall:
// it kills the ID slot, drops stall_if and inserts a bubble. ex_valido marks a
// real instruction in ID/EX; it is high exactly one cycle after an accepted
// (valid, not stalled, not flushed) instruction.
// -----------------------------------------------------------------------------
module etapa_id_segmentada #(
    parameter int ANCHO_DATO      = 32,
    parameter int NUM_REGS        = 32,
    parameter bit HABILITA_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruccion_if,
    input  logic [31:0]           pc_plus4_if,
    input  logic                  valido_if,
    input  logic                  wb_escribir,
    input  logic [4:0]            wb_rd,
    input  logic [ANCHO_DATO-1:0] wb_dato,
    input  logic                  ex_mem_leer_in,
    input  logic [4:0]            ex_rt_in,
    input  logic                  flush,
    output logic                  stall_if,
    output logic                  salto_id,
    output logic [31:0]           dir_salto,
    output logic                  ex_valido,
    output logic                  ex_reg_escribir,
    output logic                  ex_mem_leer,
    output logic                  ex_mem_escribir,
    output logic                  ex_mem_a_reg,
    output logic                  ex_alu_fuente,
    output logic                  ex_branch,
    output logic [1:0]            ex_alu_op,
    output logic [ANCHO_DATO-1:0] ex_dr1,
    output logic [ANCHO_DATO-1:0] ex_dr2,
    output logic [ANCHO_DATO-1:0] ex_ext,
    output logic [4:0]            ex_rs,
    output logic [4:0]            ex_rt,
    output logic [4:0]            ex_rd_dest,
    output logic [5:0]            ex_funct,
    output logic [31:0]           ex_pc_plus4,
    output logic                  ex_ilegal
);

    // Bank index width: low log2(NUM_REGS) bits of each 5-bit register field.
    localparam int IDX = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic                  valido;
        logic                  reg_escribir;
        logic                  mem_leer;
        logic                  mem_escribir;
        logic                  mem_a_reg;
        logic                  alu_fuente;
        logic                  branch;
        logic [1:0]            alu_op;
        logic                  ilegal;
        logic [ANCHO_DATO-1:0] dr1;
        logic [ANCHO_DATO-1:0] dr2;
        logic [ANCHO_DATO-1:0] ext;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd_dest;
        logic [5:0]            funct;
        logic [31:0]           pc_plus4;
    } id_ex_t;

    // ---------------------------------------------------------------- fields
    logic [5:0]  opcode;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [IDX-1:0] rs_i;
    logic [IDX-1:0] rt_i;
    logic [IDX-1:0] wb_i;
    logic signed [15:0] imm;

    assign opcode = instruccion_if[31:26];
    assign rs_f   = instruccion_if[25:21];
    assign rt_f   = instruccion_if[20:16];
    assign rd_f   = instruccion_if[15:11];
    assign rs_i   = rs_f[IDX-1:0];
    assign rt_i   = rt_f[IDX-1:0];
    assign wb_i   = wb_rd[IDX-1:0];
    assign imm    = instruccion_if[15:0];

    // ---------------------------------------------------------- register bank
    logic [ANCHO_DATO-1:0] banco [NUM_REGS];

    // Entry 0 is never written; its reads are forced to zero below anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                banco[i] <= '0;
            end
        end else if (wb_escribir && (wb_i != '0)) begin
            banco[wb_i] <= wb_dato;
        end
    end

    // Read ports. A WB write to the same register in this cycle is forwarded
    // so the decoded operand is not one cycle stale.
    logic [ANCHO_DATO-1:0] dr1;
    logic [ANCHO_DATO-1:0] dr2;

    always_comb begin
        dr1 = '0;
        if (rs_i != '0) begin
            if (HABILITA_BYPASS && wb_escribir && (wb_i == rs_i)) begin
                dr1 = wb_dato;
            end else begin
                dr1 = banco[rs_i];
            end
        end
    end

    always_comb begin
        dr2 = '0;
        if (rt_i != '0) begin
            if (HABILITA_BYPASS && wb_escribir && (wb_i == rt_i)) begin
                dr2 = wb_dato;
            end else begin
                dr2 = banco[rt_i];
            end
        end
    end

    // ------------------------------------------------------------------ decode
    id_ex_t siguiente;

    always_comb begin
        siguiente          = '0;
        siguiente.valido   = 1'b1;
        siguiente.dr1      = dr1;
        siguiente.dr2      = dr2;
        siguiente.ext      = ANCHO_DATO'(imm);
        siguiente.rs       = rs_f;
        siguiente.rt       = rt_f;
        siguiente.funct    = instruccion_if[5:0];
        siguiente.pc_plus4 = pc_plus4_if;
        // rd_dest stays 0 for instructions that do not write the bank.
        case (opcode)
            OP_R: begin
                siguiente.rd_dest      = rd_f;
                siguiente.reg_escribir = 1'b1;
                siguiente.alu_op       = 2'b10;
            end
            OP_LW: begin
                siguiente.rd_dest      = rt_f;
                siguiente.reg_escribir = 1'b1;
                siguiente.mem_leer     = 1'b1;
                siguiente.mem_a_reg    = 1'b1;
                siguiente.alu_fuente   = 1'b1;
            end
            OP_SW: begin
                siguiente.mem_escribir = 1'b1;
                siguiente.alu_fuente   = 1'b1;
            end
            OP_BEQ: begin
                siguiente.branch = 1'b1;
                siguiente.alu_op = 2'b01;
            end
            OP_ADDI: begin
                siguiente.rd_dest      = rt_f;
                siguiente.reg_escribir = 1'b1;
                siguiente.alu_fuente   = 1'b1;
            end
            OP_J: begin
                // Resolved here through salto_id; no EX control needed.
            end
            default: begin
                siguiente.ilegal = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------- load-use / jump
    // rt is a source operand only for R-type, SW and BEQ; for LW/ADDI it is
    // the destination, so a match on it is not a hazard.
    logic lee_rt;
    logic carga_pendiente;

    assign lee_rt          = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign carga_pendiente = ex_mem_leer_in && (ex_rt_in != 5'd0) &&
                             ((ex_rt_in == rs_f) || ((ex_rt_in == rt_f) && lee_rt));
    assign stall_if        = valido_if && !flush && carga_pendiente;
    assign salto_id        = valido_if && (opcode == OP_J) && !flush && !stall_if && !rst;
    assign dir_salto       = {pc_plus4_if[31:28], instruccion_if[25:0], 2'b00};

    // ------------------------------------------------------------------ ID/EX
    id_ex_t id_ex;

    // Reset, flush, stall and an empty IF/ID slot all load the same bubble.
    always_ff @(posedge clk) begin
        if (rst || flush || stall_if || !valido_if) begin
            id_ex <= '0;
        end else begin
            id_ex <= siguiente;
        end
    end

    assign ex_valido       = id_ex.valido;
    assign ex_reg_escribir = id_ex.reg_escribir;
    assign ex_mem_leer     = id_ex.mem_leer;
    assign ex_mem_escribir = id_ex.mem_escribir;
    assign ex_mem_a_reg    = id_ex.mem_a_reg;
    assign ex_alu_fuente   = id_ex.alu_fuente;
    assign ex_branch       = id_ex.branch;
    assign ex_alu_op       = id_ex.alu_op;
    assign ex_ilegal       = id_ex.ilegal;
    assign ex_dr1          = id_ex.dr1;
    assign ex_dr2          = id_ex.dr2;
    assign ex_ext          = id_ex.ext;
    assign ex_rs           = id_ex.rs;
    assign ex_rt           = id_ex.rt;
    assign ex_rd_dest      = id_ex.rd_dest;
    assign ex_funct        = id_ex.funct;
    assign ex_pc_plus4     = id_ex.pc_plus4;

endmodule

// File: tb/tb_etapa_id_segmentada.sv
// -----------------------------------------------------------------------------
// tb_etapa_id_segmentada
//
// Self-checking bench for etapa_id_segmentada (default parameters). A fixed
// table of hand-computed vectors, a few multi-cycle sequences (held load-use
// stall, mid-stream reset, full register readback) and a randomized phase.
// Every cycle is also checked against a behavioural model: an array holding
// the architectural register file plus opcode-driven decode rules.
// -----------------------------------------------------------------------------
module tb_etapa_id_segmentada;

    // ------------------------------------------------------ clock and signals
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] instruccion_if;
    logic [31:0] pc_plus4_if;
    logic        valido_if;
    logic        wb_escribir;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dato;
    logic        ex_mem_leer_in;
    logic [4:0]  ex_rt_in;
    logic        flush;
    logic        stall_if;
    logic        salto_id;
    logic [31:0] dir_salto;
    logic        ex_valido;
    logic        ex_reg_escribir;
    logic        ex_mem_leer;
    logic        ex_mem_escribir;
    logic        ex_mem_a_reg;
    logic        ex_alu_fuente;
    logic        ex_branch;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_dr1;
    logic [31:0] ex_dr2;
    logic [31:0] ex_ext;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd_dest;
    logic [5:0]  ex_funct;
    logic [31:0] ex_pc_plus4;
    logic        ex_ilegal;

    etapa_id_segmentada dut (
        .clk             (clk),
        .rst             (rst),
        .instruccion_if  (instruccion_if),
        .pc_plus4_if     (pc_plus4_if),
        .valido_if       (valido_if),
        .wb_escribir     (wb_escribir),
        .wb_rd           (wb_rd),
        .wb_dato         (wb_dato),
        .ex_mem_leer_in  (ex_mem_leer_in),
        .ex_rt_in        (ex_rt_in),
        .flush           (flush),
        .stall_if        (stall_if),
        .salto_id        (salto_id),
        .dir_salto       (dir_salto),
        .ex_valido       (ex_valido),
        .ex_reg_escribir (ex_reg_escribir),
        .ex_mem_leer     (ex_mem_leer),
        .ex_mem_escribir (ex_mem_escribir),
        .ex_mem_a_reg    (ex_mem_a_reg),
        .ex_alu_fuente   (ex_alu_fuente),
        .ex_branch       (ex_branch),
        .ex_alu_op       (ex_alu_op),
        .ex_dr1          (ex_dr1),
        .ex_dr2          (ex_dr2),
        .ex_ext          (ex_ext),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd_dest      (ex_rd_dest),
        .ex_funct        (ex_funct),
        .ex_pc_plus4     (ex_pc_plus4),
        .ex_ilegal       (ex_ilegal)
    );

    // ---------------------------------------------------------------- types
    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valido;
        logic        wbw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        ldr;
        logic [4:0]  ert;
        logic        flush;
    } in_t;

    typedef struct {
        in_t         in;
        bit          e_stall;
        bit          e_salto;
        bit          chk_dir;
        logic [31:0] e_dir;
        bit          e_valido;
        logic [8:0]  e_ctrl;
        logic [31:0] e_dr1;
        logic [31:0] e_dr2;
    } vec_t;

    typedef struct packed {
        logic        valido;
        logic [8:0]  ctrl;
        logic [31:0] dr1;
        logic [31:0] dr2;
        logic [31:0] ext;
        logic [20:0] regs;
        logic [31:0] pc;
    } exp_t;

    // Control word layout: {reg_escribir, mem_leer, mem_escribir, mem_a_reg,
    //                       alu_fuente, branch, alu_op[1:0], ilegal}
    localparam logic [8:0] C_R    = 9'b1_0_0_0_0_0_10_0;
    localparam logic [8:0] C_LW   = 9'b1_1_0_1_1_0_00_0;
    localparam logic [8:0] C_SW   = 9'b0_0_1_0_1_0_00_0;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_1_01_0;
    localparam logic [8:0] C_ADDI = 9'b1_0_0_0_1_0_00_0;
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_00_0;
    localparam logic [8:0] C_ILEG = 9'b0_0_0_0_0_0_00_1;

    localparam logic [31:0] I_ADD356  = 32'h00A6_1820; // add r3,r5,r6
    localparam logic [31:0] I_ADD300  = 32'h0000_1820; // add r3,r0,r0
    localparam logic [31:0] I_SW      = 32'hAD28_0004; // sw  r8,4(r9)
    localparam logic [31:0] I_LW      = 32'h8CA7_0008; // lw  r7,8(r5)
    localparam logic [31:0] I_ADDI    = 32'h2048_FFFF; // addi r8,r2,-1
    localparam logic [31:0] I_BEQ     = 32'h10A6_0010; // beq r5,r6,0x10
    localparam logic [31:0] I_J       = 32'h0800_0040; // j 0x0000040
    localparam logic [31:0] I_ILEG    = 32'hFC00_0000; // opcode 111111

    // ------------------------------------------------------------ scoreboard
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ behavioural model
    logic [31:0] m_regs [32];

    function automatic logic [8:0] m_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return C_R;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h02:   return C_NONE;
            default: return C_ILEG;
        endcase
    endfunction

    // Architectural value of a register as ID must see it this cycle.
    function automatic logic [31:0] m_read(input logic [4:0] r, input in_t v);
        if (r == 5'd0) return 32'h0;
        if (v.wbw && v.wrd == r) return v.wdat;
        return m_regs[r];
    endfunction

    // ---------------------------------------------------------------- driver
    vec_t none;

    task automatic do_cycle(input in_t v, input bit has_row, input vec_t row);
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        bit          reads_rt;
        bit          m_stall;
        bit          m_salto;
        logic [31:0] m_dir;
        exp_t        e;

        @(negedge clk);
        rst            = v.rst;
        instruccion_if = v.instr;
        pc_plus4_if    = v.pc;
        valido_if      = v.valido;
        wb_escribir    = v.wbw;
        wb_rd          = v.wrd;
        wb_dato        = v.wdat;
        ex_mem_leer_in = v.ldr;
        ex_rt_in       = v.ert;
        flush          = v.flush;
        #1;

        op       = v.instr[31:26];
        rs       = v.instr[25:21];
        rt       = v.instr[20:16];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        m_stall  = v.valido && !v.flush && v.ldr && (v.ert != 5'd0) &&
                   ((v.ert == rs) || ((v.ert == rt) && reads_rt));
        m_salto  = v.valido && (op == 6'h02) && !v.flush && !m_stall && !v.rst;
        m_dir    = {v.pc[31:28], v.instr[25:0], 2'b00};

        chk("stall_if", 64'(stall_if), 64'(m_stall));
        chk("salto_id", 64'(salto_id), 64'(m_salto));
        chk("dir_salto", 64'(dir_salto), 64'(m_dir));
        if (has_row) begin
            chk("row_stall_if", 64'(stall_if), 64'(row.e_stall));
            chk("row_salto_id", 64'(salto_id), 64'(row.e_salto));
            if (row.chk_dir) chk("row_dir_salto", 64'(dir_salto), 64'(row.e_dir));
        end

        e = '0;
        if (!(v.rst || v.flush || m_stall || !v.valido)) begin
            if (op == 6'h00)                     dest = v.instr[15:11];
            else if (op == 6'h23 || op == 6'h08) dest = rt;
            else                                 dest = 5'd0;
            e.valido = 1'b1;
            e.ctrl   = m_ctrl(op);
            e.dr1    = m_read(rs, v);
            e.dr2    = m_read(rt, v);
            e.ext    = {{16{v.instr[15]}}, v.instr[15:0]};
            e.regs   = {rs, rt, dest, v.instr[5:0]};
            e.pc     = v.pc;
        end

        @(posedge clk);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (v.wbw && v.wrd != 5'd0) begin
            m_regs[v.wrd] = v.wdat;
        end
        #1;

        chk("ex_valido", 64'(ex_valido), 64'(e.valido));
        chk("ex_ctrl", 64'({ex_reg_escribir, ex_mem_leer, ex_mem_escribir, ex_mem_a_reg,
                            ex_alu_fuente, ex_branch, ex_alu_op, ex_ilegal}), 64'(e.ctrl));
        chk("ex_dr1", 64'(ex_dr1), 64'(e.dr1));
        chk("ex_dr2", 64'(ex_dr2), 64'(e.dr2));
        chk("ex_ext", 64'(ex_ext), 64'(e.ext));
        chk("ex_fields", 64'({ex_rs, ex_rt, ex_rd_dest, ex_funct}), 64'(e.regs));
        chk("ex_pc_plus4", 64'(ex_pc_plus4), 64'(e.pc));
        if (has_row) begin
            chk("row_ex_valido", 64'(ex_valido), 64'(row.e_valido));
            chk("row_ex_ctrl", 64'({ex_reg_escribir, ex_mem_leer, ex_mem_escribir, ex_mem_a_reg,
                                    ex_alu_fuente, ex_branch, ex_alu_op, ex_ilegal}), 64'(row.e_ctrl));
            chk("row_ex_dr1", 64'(ex_dr1), 64'(row.e_dr1));
            chk("row_ex_dr2", 64'(ex_dr2), 64'(row.e_dr2));
        end
    endtask

    function automatic in_t mk_in(input logic [31:0] instr, input logic valido,
                                  input logic wbw, input logic [4:0] wrd, input logic [31:0] wdat,
                                  input logic ldr, input logic [4:0] ert, input logic fl);
        in_t v;
        v.rst    = 1'b0;
        v.instr  = instr;
        v.pc     = 32'h4000_0010;
        v.valido = valido;
        v.wbw    = wbw;
        v.wrd    = wrd;
        v.wdat   = wdat;
        v.ldr    = ldr;
        v.ert    = ert;
        v.flush  = fl;
        return v;
    endfunction

    function automatic vec_t mk_row(input in_t v, input bit st, input bit sa, input bit va,
                                    input logic [8:0] c, input logic [31:0] d1, input logic [31:0] d2);
        vec_t r;
        r.in       = v;
        r.e_stall  = st;
        r.e_salto  = sa;
        r.chk_dir  = 1'b0;
        r.e_dir    = 32'h0;
        r.e_valido = va;
        r.e_ctrl   = c;
        r.e_dr1    = d1;
        r.e_dr2    = d2;
        return r;
    endfunction

    // ----------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- test
    vec_t tbl [16];

    initial begin
        in_t v;
        vec_t r;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        none = mk_row(mk_in(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0),
                      1'b0, 1'b0, 1'b0, C_NONE, 32'h0, 32'h0);

        // Vectors assume an all-zero bank at row 0 and run back to back.
        tbl[0]  = mk_row(mk_in(I_ADD356, 1, 1, 5'd5, 32'h1234, 0, 5'd0, 0), 0, 0, 1, C_R,    32'h1234, 32'h0);
        tbl[1]  = mk_row(mk_in(I_ADD356, 1, 1, 5'd6, 32'h0055, 0, 5'd0, 0), 0, 0, 1, C_R,    32'h1234, 32'h55);
        tbl[2]  = mk_row(mk_in(I_SW,     1, 0, 5'd0, 32'h0,    1, 5'd8, 0), 1, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[3]  = mk_row(mk_in(I_SW,     1, 0, 5'd0, 32'h0,    0, 5'd8, 0), 0, 0, 1, C_SW,   32'h0,    32'h0);
        tbl[4]  = mk_row(mk_in(I_LW,     1, 0, 5'd0, 32'h0,    1, 5'd0, 0), 0, 0, 1, C_LW,   32'h1234, 32'h0);
        tbl[5]  = mk_row(mk_in(I_ADDI,   1, 0, 5'd0, 32'h0,    1, 5'd8, 0), 0, 0, 1, C_ADDI, 32'h0,    32'h0);
        tbl[6]  = mk_row(mk_in(I_BEQ,    1, 0, 5'd0, 32'h0,    1, 5'd6, 0), 1, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[7]  = mk_row(mk_in(I_J,      1, 0, 5'd0, 32'h0,    0, 5'd0, 0), 0, 1, 1, C_NONE, 32'h0,    32'h0);
        tbl[8]  = mk_row(mk_in(I_J,      1, 0, 5'd0, 32'h0,    0, 5'd0, 1), 0, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[9]  = mk_row(mk_in(I_ILEG,   1, 0, 5'd0, 32'h0,    0, 5'd0, 0), 0, 0, 1, C_ILEG, 32'h0,    32'h0);
        tbl[10] = mk_row(mk_in(I_ADD300, 1, 1, 5'd0, 32'hDEAD, 0, 5'd0, 0), 0, 0, 1, C_R,    32'h0,    32'h0);
        tbl[11] = mk_row(mk_in(I_ADD300, 1, 0, 5'd0, 32'h0,    0, 5'd0, 0), 0, 0, 1, C_R,    32'h0,    32'h0);
        tbl[12] = mk_row(mk_in(I_ADD356, 0, 0, 5'd0, 32'h0,    1, 5'd5, 0), 0, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[13] = mk_row(mk_in(I_SW,     1, 0, 5'd0, 32'h0,    1, 5'd9, 1), 0, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[14] = mk_row(mk_in(I_ADD356, 1, 0, 5'd0, 32'h0,    1, 5'd5, 0), 1, 0, 0, C_NONE, 32'h0,    32'h0);
        tbl[15] = mk_row(mk_in(I_ADD356, 1, 0, 5'd0, 32'h0,    1, 5'd0, 0), 0, 0, 1, C_R,    32'h1234, 32'h55);
        tbl[7].chk_dir = 1'b1;
        tbl[7].e_dir   = 32'h4000_0100;
        tbl[8].chk_dir = 1'b1;
        tbl[8].e_dir   = 32'h4000_0100;

        // Power-on reset: two cycles, J in IF/ID must not be taken.
        v = mk_in(I_J, 1, 1, 5'd4, 32'hBEEF, 0, 5'd0, 0);
        v.rst = 1'b1;
        r = mk_row(v, 0, 0, 0, C_NONE, 32'h0, 32'h0);
        do_cycle(v, 1'b1, r);
        do_cycle(v, 1'b1, r);

        for (int i = 0; i < 16; i++) do_cycle(tbl[i].in, 1'b1, tbl[i]);

        // Load-use hazard held for three cycles, then released.
        v = mk_in(I_SW, 1, 0, 5'd0, 32'h0, 1, 5'd8, 0);
        r = mk_row(v, 1, 0, 0, C_NONE, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) do_cycle(v, 1'b1, r);
        v.ldr = 1'b0;
        r = mk_row(v, 0, 0, 1, C_SW, 32'h0, 32'h0);
        do_cycle(v, 1'b1, r);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rnd;
            logic [5:0]  op;
            rnd = $urandom();
            case ($urandom_range(0, 7))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                5: op = 6'h02;
                default: op = 6'($urandom_range(0, 63));
            endcase
            v.rst    = ($urandom_range(0, 99) == 0);
            if (op == 6'h02)
                v.instr = {op, rnd[25:0]};
            else
                v.instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), rnd[10:0]};
            v.pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            v.valido = ($urandom_range(0, 9) != 0);
            v.wbw    = $urandom_range(0, 1);
            v.wrd    = 5'($urandom_range(0, 7));
            v.wdat   = $urandom();
            v.ldr    = ($urandom_range(0, 2) == 0);
            v.ert    = 5'($urandom_range(0, 7));
            v.flush  = ($urandom_range(0, 9) == 0);
            do_cycle(v, 1'b0, none);
        end

        // Mid-stream reset for two cycles with writes and a J pending.
        v = mk_in(I_J, 1, 1, 5'd5, 32'hCAFE, 0, 5'd0, 0);
        v.rst = 1'b1;
        r = mk_row(v, 0, 0, 0, C_NONE, 32'h0, 32'h0);
        do_cycle(v, 1'b1, r);
        do_cycle(v, 1'b1, r);

        // Every register reads zero afterwards.
        for (int i = 1; i < 32; i++) begin
            v = mk_in({6'd0, 5'(i), 5'(i), 5'd3, 5'd0, 6'h20}, 1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
            r = mk_row(v, 0, 0, 1, C_R, 32'h0, 32'h0);
            do_cycle(v, 1'b1, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
